// File: rtl/sumador_serial.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, LSB first,
// N cycles per operation behind a start/done handshake.
module sumador_serial #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         resta,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         overflow,
  output logic [1:0]   state_dbg
);

  // Handshake: start is sampled only in IDLE, where it captures a/b/cin/resta
  // on that edge; done pulses for one cycle when sum/cout/overflow are final.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUMA = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic           carry_q, carry_d;
  logic [N-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;

  logic           s_bit;
  logic           c_next;

  assign s_bit  = a_q[0] ^ b_q[0] ^ carry_q;
  assign c_next = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + ~cin, so only the operand and carry inverters change.
          a_d     = a;
          b_d     = resta ? ~b : b;
          carry_d = resta ? ~cin : cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = SUMA;
        end
      end
      SUMA: begin
        carry_d = c_next;
        sum_d   = {s_bit, sum_q[N-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        if (cnt_q == LAST) begin
          // On the MSB, carry_q is the carry into it and c_next the carry out.
          cout_d  = c_next;
          ovf_d   = carry_q ^ c_next;
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy      = (state_q == SUMA);
  assign done      = (state_q == FIN);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign state_dbg = state_q;

endmodule
